// File: rtl/volume_button_encoder.sv
// volume_button_encoder: synchronizes and debounces the raw volume up/down
// buttons. It emits single-cycle step pulses on inc_dec, and auto-repeats
// while a single button is held.
//
// Ports:
//   clk      - system clock, rising edge
//   rst_n    - asynchronous active-low reset
//   btn_up   - raw up button (asynchronous, 1 = pressed)
//   btn_down - raw down button (asynchronous, 1 = pressed)
//   inc_dec  - registered step pulse: 2'b10 up, 2'b01 down, 2'b00 idle
module volume_button_encoder #(
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  parameter int unsigned REPEAT_DELAY    = 25000000,
  parameter int unsigned REPEAT_RATE     = 5000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_up,
  input  logic       btn_down,
  output logic [1:0] inc_dec
);

  localparam int unsigned CW = 26;
  localparam logic [CW-1:0] DB_LIM    = CW'(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] DELAY_LIM = CW'(REPEAT_DELAY);
  localparam logic [CW-1:0] RATE_LIM  = CW'(REPEAT_RATE);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    DELAY   = 2'd1,
    REPEAT  = 2'd2,
    LOCKOUT = 2'd3
  } state_t;

  // Bit 1 carries the up button, bit 0 the down button, matching inc_dec.
  logic [1:0]    sync1;
  logic [1:0]    sync2;
  logic [1:0]    level;
  logic [CW-1:0] db_cnt [2];

  state_t        state;
  state_t        state_nxt;
  logic [CW-1:0] rpt_cnt;
  logic [CW-1:0] rpt_cnt_nxt;
  logic [CW-1:0] rpt_inc;
  logic [CW-1:0] rpt_lim;
  logic          dir;
  logic          dir_nxt;
  logic          pulse_nxt;
  logic          held;
  logic          opposite;
  logic          pulse_busy;

  // Two-flop synchronizer followed by per-button stable-count debounce.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1     <= 2'b00;
      sync2     <= 2'b00;
      level     <= 2'b00;
      db_cnt[0] <= '0;
      db_cnt[1] <= '0;
    end else begin
      sync1 <= {btn_up, btn_down};
      sync2 <= sync1;
      for (int i = 0; i < 2; i++) begin
        if (sync2[i] == level[i]) begin
          db_cnt[i] <= '0;
        end else if (CW'(db_cnt[i] + CW'(1)) >= DB_LIM) begin
          level[i]  <= sync2[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= CW'(db_cnt[i] + CW'(1));
        end
      end
    end
  end

  // FSM state, repeat counter, direction and the registered pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      rpt_cnt <= '0;
      dir     <= 1'b0;
      inc_dec <= 2'b00;
    end else begin
      state   <= state_nxt;
      rpt_cnt <= rpt_cnt_nxt;
      dir     <= dir_nxt;
      inc_dec <= pulse_nxt ? (dir_nxt ? 2'b10 : 2'b01) : 2'b00;
    end
  end

  // Next-state logic: release and lockout outrank a pulse due on the same edge.
  always_comb begin
    state_nxt   = state;
    rpt_cnt_nxt = rpt_cnt;
    dir_nxt     = dir;
    pulse_nxt   = 1'b0;
    held        = dir ? level[1] : level[0];
    opposite    = dir ? level[0] : level[1];
    rpt_inc     = CW'(rpt_cnt + CW'(1));
    rpt_lim     = (state == DELAY) ? DELAY_LIM : RATE_LIM;
    pulse_busy  = |inc_dec;

    case (state)
      IDLE: begin
        if (level == 2'b11) begin
          state_nxt = LOCKOUT;
        end else if (level != 2'b00) begin
          dir_nxt     = level[1];
          pulse_nxt   = 1'b1;
          rpt_cnt_nxt = '0;
          state_nxt   = DELAY;
        end
      end
      DELAY, REPEAT: begin
        if (!held) begin
          state_nxt   = IDLE;
          rpt_cnt_nxt = '0;
        end else if (opposite) begin
          state_nxt   = LOCKOUT;
          rpt_cnt_nxt = '0;
        end else if (rpt_inc >= rpt_lim) begin
          // A due pulse waits one cycle if the previous pulse is still out,
          // so inc_dec never stays nonzero on back-to-back cycles.
          if (!pulse_busy) begin
            pulse_nxt   = 1'b1;
            rpt_cnt_nxt = '0;
            state_nxt   = REPEAT;
          end
        end else begin
          rpt_cnt_nxt = rpt_inc;
        end
      end
      LOCKOUT: begin
        if (level == 2'b00) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt   = IDLE;
        rpt_cnt_nxt = '0;
      end
    endcase
  end

endmodule

// File: doc/volume_button_encoder.md
# volume_button_encoder

Front-end for the volume push buttons. It synchronizes and debounces the raw up/down buttons and generates the single-cycle `inc_dec` step pulses that drive the volume step counter. Holding a button auto-repeats after a delay. It sits between the board button pins and the volume step counter, and drives the `inc_dec` interface the counter consumes.

## Interface
- `DEBOUNCE_CYCLES`, default 50000: consecutive stable cycles required to accept a button level change; must be ≥1.
- `REPEAT_DELAY`, default 25000000: cycles from the first pulse to the first auto-repeat pulse; must be ≥1.
- `REPEAT_RATE`, default 5000000: cycles between subsequent auto-repeat pulses; must be ≥1.
- All parameters must be < 2^26. Internal counters are 26 bits.
- `clk` input 1: single system clock; all logic runs on the rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `btn_up` input 1: raw up button, asynchronous, 1 = pressed.
- `btn_down` input 1: raw down button, asynchronous, 1 = pressed.
- `inc_dec` output 2: registered step pulse. 2'b10 = increment, 2'b01 = decrement, 2'b00 = idle. 2'b11 is never driven.

## Operation
**Reset.** While `rst_n` = 0:
- All synchronizer flops, debounced levels and counters are 0.
- The FSM is in IDLE.
- `inc_dec` = 2'b00.
- Reset asserted mid-operation aborts any repeat immediately.

**Synchronization.** Each button passes through two flops.

**Debounce, per button.**
- The counter increments on every edge where the synced level differs from the debounced level. It clears on any edge where they are equal.
- On the edge where the counter reaches `DEBOUNCE_CYCLES`, the debounced level takes the synced value and the counter clears.

**FSM.** States: IDLE, DELAY, REPEAT, LOCKOUT. There is one repeat counter and a direction register `dir`.
- IDLE:
  - Exactly one debounced button high: latch `dir`, emit one pulse, clear the counter, go to DELAY.
  - Both high: go to LOCKOUT with no pulse.
- DELAY:
  - The counter increments each cycle.
  - When it reaches `REPEAT_DELAY`: emit a pulse, clear the counter, go to REPEAT.
- REPEAT:
  - The counter increments each cycle.
  - When it reaches `REPEAT_RATE`: emit a pulse and clear the counter.
- In DELAY or REPEAT:
  - Held button released: go to IDLE, no pulse. Release takes priority over a pulse due on the same edge.
  - Opposite button becomes high: go to LOCKOUT, no pulse. This also takes priority over a due pulse.
- LOCKOUT: no pulses. When both debounced levels are 0, go to IDLE.

**Pulse.** `inc_dec` is the one-cycle registered pulse: 2'b10 if `dir` = up, 2'b01 if `dir` = down. It returns to 2'b00 on the next edge.

**Held through reset.** A button held while `rst_n` deasserts is treated as a new press after the normal latency.

## Timing
Edge 0 is the first rising edge that samples the raw button high, with the button held from then on. D = `DEBOUNCE_CYCLES`.
- Synced level is high after edge 1.
- The debounce counter increments on edges 2 through D+1; the debounced level is high after edge D+1.
- First pulse: `inc_dec` is nonzero after edge D+2 and 2'b00 after edge D+3.
- First repeat pulse: edge D+2+`REPEAT_DELAY`.
- Each later repeat: every `REPEAT_RATE` edges after the previous pulse.
- Release latency is symmetric: the debounced level falls D+1 edges after the first low sample, and no pulse is produced after that edge.
- A raw glitch shorter than D consecutive synced cycles never changes the debounced level.
- `inc_dec` is never high on two consecutive cycles, even with `REPEAT_RATE` = 1. With `REPEAT_RATE` = 1 the pulse interval is 2 cycles.

## Test plan
All scenarios use `DEBOUNCE_CYCLES`=4, `REPEAT_DELAY`=10, `REPEAT_RATE`=3.

1. Press `btn_up` at edge 0 and release at edge 8 → exactly one 2'b10 pulse, high after edge 6 only. No further pulses.
2. Hold `btn_down` for 40 cycles → 2'b01 pulses after edges 6, 16, 19, 22, 25, … while held. After release is debounced, `inc_dec` stays 2'b00.
3. Apply a `btn_up` glitch 3 cycles wide, then idle for 20 cycles → `inc_dec` stays 2'b00 throughout.
4. Press both buttons on the same edge → no pulse. Release both, then press `btn_up` alone → one 2'b10 pulse D+2 edges after the new press.
5. Hold `btn_up` into REPEAT, then press `btn_down` → no further pulses in either direction until both are released and debounced.
6. Hold `btn_up`, assert `rst_n`=0 for 2 cycles mid-DELAY, release reset while still holding → `inc_dec` is 2'b00 immediately on reset assertion (asynchronous). A fresh 2'b10 pulse follows D+2 edges after the first post-reset sampling edge.
